axis_sat_fifo: RTL and testbench

Downstream stage for the packet overlap-add stage. It accepts that stage's (DATA_WIDTH+1)-bit AXI-Stream output and saturates each beat back to DATA_WIDTH bits. Beats and their last flag are buffered in a first-word-fall-through FIFO, then presented as a standard AXI-Stream master. Saturation and completed-packet statistics are exported for software.

---
 rtl/axis_sat_fifo.sv | 87 ++++++++
 tb/tb_axis_sat_fifo.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_sat_fifo.sv
// axis_sat_fifo: saturates (DATA_WIDTH+1)-bit AXI-Stream beats to DATA_WIDTH
// bits, buffers {last, sample} in a first-word-fall-through FIFO and exports
// saturation / delivered-packet statistics.
//
// Handshake semantics (both ports): a beat transfers on a rising clk edge
// exactly when valid && ready are both high in the cycle before that edge.
// A master never waits for ready before raising valid. Once valid is high,
// data/last hold stable until the transfer happens. s_axis_ready depends only
// on the registered fifo_count, so a full FIFO refuses a write even when a
// read happens in the same cycle.
module axis_sat_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [DATA_WIDTH:0]       s_axis_data,
  input  logic                      s_axis_valid,
  input  logic                      s_axis_last,
  output logic                      s_axis_ready,
  output logic [DATA_WIDTH-1:0]     m_axis_data,
  output logic                      m_axis_valid,
  output logic                      m_axis_last,
  input  logic                      m_axis_ready,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic [15:0]               sat_count,
  output logic [15:0]               pkt_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  wr;
  logic                  rd;
  logic                  sat_beat;
  logic [DATA_WIDTH-1:0] sat_data;
  logic [DATA_WIDTH:0]   head;

  // Handshakes, saturation and FWFT output decode from registered state
  always_comb begin
    s_axis_ready = resetn && (fifo_count != FULL_COUNT);
    m_axis_valid = (fifo_count != '0);
    wr           = s_axis_valid && s_axis_ready;
    rd           = m_axis_valid && m_axis_ready;
    sat_beat     = s_axis_data[DATA_WIDTH];
    sat_data     = sat_beat ? {DATA_WIDTH{1'b1}} : s_axis_data[DATA_WIDTH-1:0];
    head         = mem[rd_ptr];
    m_axis_data  = m_axis_valid ? head[DATA_WIDTH-1:0] : '0;
    m_axis_last  = m_axis_valid ? head[DATA_WIDTH] : 1'b0;
  end

  // Storage array; intentionally not reset, contents are don't-care when empty
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= {s_axis_last, sat_data};
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      if (wr && !rd)      fifo_count <= fifo_count + 1'b1;
      else if (rd && !wr) fifo_count <= fifo_count - 1'b1;
    end
  end

  // Statistics counters, sticky at all ones instead of wrapping
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sat_count <= '0;
      pkt_count <= '0;
    end else begin
      if (wr && sat_beat && (sat_count != 16'hFFFF)) sat_count <= sat_count + 1'b1;
      if (rd && head[DATA_WIDTH] && (pkt_count != 16'hFFFF)) pkt_count <= pkt_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_sat_fifo.sv
// tb_axis_sat_fifo: directed sequence with a scoreboard queue of expected
// {last, sample} beats, checked with immediate assertions.
module tb_axis_sat_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk;
  logic          resetn;
  logic [DW:0]   s_axis_data;
  logic          s_axis_valid;
  logic          s_axis_last;
  logic          s_axis_ready;
  logic [DW-1:0] m_axis_data;
  logic          m_axis_valid;
  logic          m_axis_last;
  logic          m_axis_ready;
  logic [4:0]    fifo_count;
  logic [15:0]   sat_count;
  logic [15:0]   pkt_count;

  logic [DW:0]   exp_q[$];
  int            exp_sat;
  int            exp_pkt;
  int            n_rd;
  int            n_checks;
  int            n_fail;
  bit            stream_done;

  axis_sat_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .s_axis_data  (s_axis_data),
    .s_axis_valid (s_axis_valid),
    .s_axis_last  (s_axis_last),
    .s_axis_ready (s_axis_ready),
    .m_axis_data  (m_axis_data),
    .m_axis_valid (m_axis_valid),
    .m_axis_last  (m_axis_last),
    .m_axis_ready (m_axis_ready),
    .fifo_count   (fifo_count),
    .sat_count    (sat_count),
    .pkt_count    (pkt_count)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW:0] model_beat(input logic [DW:0] d, input logic l);
    return {l, d[DW] ? {DW{1'b1}} : d[DW-1:0]};
  endfunction

  // scoreboard: pop/compare on read handshakes, push on write handshakes
  always @(negedge clk) begin
    if (resetn) begin
      if (m_axis_valid) begin
        check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          check("head_beat", {m_axis_last, m_axis_data}, exp_q[0]);
          if (m_axis_ready) begin
            if (exp_q[0][DW] && exp_pkt < 16'hFFFF) exp_pkt++;
            void'(exp_q.pop_front());
            n_rd++;
          end
        end
      end else begin
        check("idle_outputs_zero", {m_axis_last, m_axis_data}, 32'd0);
      end
      if (s_axis_valid && s_axis_ready) begin
        exp_q.push_back(model_beat(s_axis_data, s_axis_last));
        if (s_axis_data[DW] && exp_sat < 16'hFFFF) exp_sat++;
      end
    end
  end

  // driver: hold a beat until accepted, returns #1 after the accepting edge
  task automatic send_beat(input logic [DW:0] d, input logic l);
    int waited;
    s_axis_data  = d;
    s_axis_last  = l;
    s_axis_valid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (s_axis_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      waited++;
      if (waited > 500) begin
        check("send_timeout", 32'd1, 32'd0 + 32'(s_axis_ready));
        break;
      end
    end
  endtask

  task automatic idle_in();
    s_axis_valid = 1'b0;
    s_axis_data  = '0;
    s_axis_last  = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int cyc;
    cyc = 0;
    while (fifo_count != 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, 32'(fifo_count), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_sat"}, 32'(sat_count), 32'(exp_sat));
    check({tag, "_pkt"}, 32'(pkt_count), 32'(exp_pkt));
  endtask

  initial begin
    n_checks = 0; n_fail = 0; n_rd = 0;
    exp_sat = 0; exp_pkt = 0; stream_done = 1'b0;
    resetn = 1'b0;
    m_axis_ready = 1'b0;
    idle_in();

    // reset state
    #12;
    check("rst_valid", 32'(m_axis_valid), 32'd0);
    check("rst_data",  32'(m_axis_data), 32'd0);
    check("rst_last",  32'(m_axis_last), 32'd0);
    check("rst_ready", 32'(s_axis_ready), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_sat",   32'(sat_count), 32'd0);
    check("rst_pkt",   32'(pkt_count), 32'd0);
    resetn = 1'b1;
    #1;
    check("ready_after_release", 32'(s_axis_ready), 32'd1);
    @(posedge clk); #1;

    // single beat: visible one cycle after the write edge
    m_axis_ready = 1'b1;
    send_beat(9'h005, 1'b1);
    idle_in();
    check("single_valid", 32'(m_axis_valid), 32'd1);
    check("single_data",  32'(m_axis_data), 32'h05);
    check("single_last",  32'(m_axis_last), 32'd1);
    @(posedge clk); #1;
    check("single_count", 32'(fifo_count), 32'd0);
    check("single_pkt",   32'(pkt_count), 32'd1);

    // saturation patterns
    send_beat(9'h0FF, 1'b0);
    send_beat(9'h100, 1'b0);
    send_beat(9'h1A3, 1'b0);
    send_beat(9'h0A3, 1'b1);
    idle_in();
    wait_empty("sat_drain");
    check("sat_count_2", 32'(sat_count), 32'd2);
    check_stats("sat");

    // fill to full with downstream stalled
    m_axis_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_axis_data  = 9'($urandom_range(0, 511));
      s_axis_last  = (i == 15);
      s_axis_valid = 1'b1;
      @(posedge clk); #1;
      if (i >= 15) begin
        check("full_count", 32'(fifo_count), 32'd16);
        check("full_ready", 32'(s_axis_ready), 32'd0);
      end
    end
    check("full_queue", 32'(exp_q.size()), 32'd16);

    // full with simultaneous offer and read: no write, count drops
    m_axis_ready = 1'b1;
    @(posedge clk); #1;
    m_axis_ready = 1'b0;
    check("full_rd_count", 32'(fifo_count), 32'd15);
    check("full_rd_ready", 32'(s_axis_ready), 32'd1);
    idle_in();
    m_axis_ready = 1'b1;
    wait_empty("full_drain");
    check("full_drain_queue", 32'(exp_q.size()), 32'd0);
    check_stats("full");

    // streaming: three 7-beat packets with random downstream ready
    n_rd = 0;
    stream_done = 1'b0;
    fork
      begin
        for (int p = 0; p < 3; p++)
          for (int b = 0; b < 7; b++)
            send_beat(9'($urandom_range(0, 511)), b == 6);
        idle_in();
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk); #1;
          m_axis_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_axis_ready = 1'b1;
    wait_empty("stream_drain");
    check("stream_beats", 32'(n_rd), 32'd21);
    check_stats("stream");

    // reset mid-packet with 5 entries buffered
    m_axis_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_beat(9'($urandom_range(0, 511)), 1'b0);
    idle_in();
    check("pre_rst_count", 32'(fifo_count), 32'd5);
    #2;
    resetn = 1'b0;
    exp_q.delete();
    exp_sat = 0;
    exp_pkt = 0;
    #1;
    check("mid_rst_valid", 32'(m_axis_valid), 32'd0);
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    check("mid_rst_sat",   32'(sat_count), 32'd0);
    check("mid_rst_pkt",   32'(pkt_count), 32'd0);
    check("mid_rst_data",  32'(m_axis_data), 32'd0);
    @(posedge clk); #3;
    resetn = 1'b1;
    @(posedge clk); #1;
    m_axis_ready = 1'b1;
    send_beat(9'h011, 1'b0);
    send_beat(9'h1FE, 1'b1);
    idle_in();
    wait_empty("post_rst_drain");
    check("post_rst_pkt", 32'(pkt_count), 32'd1);
    check_stats("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
